booth_multiplier_32_bit: RTL and testbench
==========================================

# booth_multiplier_32_bit

Iterative radix-2 Booth multiplier for the ALU's multiply path: signed 32×32 operands, full 64-bit signed product. One Booth step per clock: conditional add/subtract of the multiplicand into the upper accumulator, then a 1-bit arithmetic right shift of the whole product register. The block sits beside the ALU datapath and returns its result to the same writeback mux as the ALU outputs.

## Interface
Parameters: none (width fixed at 32).
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; returns block to IDLE
- ctrl_MULT  in  1  start pulse; sampled only in IDLE or DONE
- data_operandA  in  32  multiplicand, signed; latched on accepted start
- data_operandB  in  32  multiplier, signed; latched on accepted start
- data_result  out  32  product[31:0]
- data_result_hi  out  32  product[63:32]
- data_exception  out  1  signed 32-bit overflow flag (see Configuration)
- data_resultRDY  out  1  one-cycle pulse, result valid
- busy  out  1  high in RUN

## Operation
- Product register P, 66 bits: acc[32:0] (33-bit, sign-extended) | mplr[31:0] | q (Booth bit).
- States: IDLE, RUN, DONE.
- IDLE/DONE + ctrl_MULT=1: mcand <= sign-extend(A) to 33 bits; P <= {33'b0, B, 1'b0}; count <= 0; -> RUN.
- IDLE + ctrl_MULT=0: stay. DONE + ctrl_MULT=0: -> IDLE.
- RUN, each edge, on {mplr[0], q}: 01 acc += mcand; 10 acc -= mcand; 00/11 no change. Then P <= P >>> 1 (sign bit acc[32] replicated). count++.
- 33-bit acc mandatory: subtracting mcand = -2^31 must not wrap.
- After 32nd step (count==31 on that edge): product = P[64:1] captured into data_result_hi/data_result; -> DONE.
- Outputs data_result/data_result_hi/data_exception hold until next result capture or reset.
- ctrl_MULT during RUN ignored; operands changing during RUN ignored.
- All arithmetic two's complement; no unsigned mode.

## Timing
- Reset values: data_result=0, data_result_hi=0, data_exception=0, data_resultRDY=0, busy=0, state IDLE, count=0, P=0.
- Start accepted at edge E0. RUN edges E1..E32; result registered at E32.
- busy high from after E0 through E32 (32 cycles).
- data_resultRDY high exactly one cycle, between E32 and E33 (DONE state).
- Back-to-back: ctrl_MULT=1 in DONE cycle accepted at E33; busy rises immediately, resultRDY falls; 33-cycle issue interval.
- reset high at any edge (including mid-RUN or DONE): aborts, all state/outputs to reset values next cycle; ctrl_MULT on the same edge ignored.
- No combinational path from inputs to outputs.

## Configuration
- MULT_OVERFLOW_DETECT_EN defined: data_exception registered at E32 as 1 when product[63:32] is not all copies of product[31] (result not representable in signed 32 bits); else 0. Held with data_result.
- Not defined: data_exception tied 0; no overflow logic synthesized. All other behaviour identical.

## Test plan
- A=3, B=5, start at E0 -> busy cycles E1..E32; resultRDY single pulse after E32; result=0x0000000F, hi=0, exception=0.
- A=-7 (0xFFFFFFF9), B=6 -> result=0xFFFFFFD6, hi=0xFFFFFFFF, exception=0.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, hi=0x00000000; exception=1 with macro, 0 without.
- A=0x00010000, B=0x00010000 -> result=0, hi=0x00000001, exception=1 (macro on).
- Start A=2,B=3; pulse ctrl_MULT with A=9,B=9 at step 10 -> ignored, result=6; then start in DONE cycle A=4,B=-4 -> accepted, result=0xFFFFFFF0 after 33 cycles.
- Start A=100,B=100; reset at step 10 -> next cycle all outputs 0, busy 0, no resultRDY; fresh start A=-1,B=-1 -> result=1, hi=0.

Source files
------------

// File: rtl/booth_multiplier_32_bit.sv
// booth_multiplier_32_bit
//
// Iterative radix-2 Booth multiplier for the ALU multiply path.
// Signed 32x32 operands give a full 64-bit signed product. The block
// performs one Booth step per clock, so a result takes 32 RUN cycles.
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high; returns the block to IDLE
//   ctrl_MULT       start pulse, only honoured in IDLE or DONE
//   data_operandA   multiplicand (signed), latched on an accepted start
//   data_operandB   multiplier (signed), latched on an accepted start
//   data_result     product[31:0], held until the next capture or reset
//   data_result_hi  product[63:32], held until the next capture or reset
//   data_exception  product does not fit in signed 32 bits
//   data_resultRDY  one-cycle pulse while in DONE
//   busy            high while in RUN
//
// Build option
//   MULT_OVERFLOW_DETECT_EN  when defined, data_exception is computed and
//                            registered alongside the result; otherwise it
//                            is tied to 0 and no overflow logic exists.
//
// State   | Meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for ctrl_MULT
// RUN     | one Booth step per edge, 32 steps
// DONE    | result valid for one cycle; may accept a new start

module booth_multiplier_32_bit (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic [31:0] data_result_hi,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    // P = acc[32:0] | mplr[31:0] | q
    logic [65:0] p_q, p_d;
    logic [32:0] mcand_q, mcand_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;

    logic [32:0] acc_next;
    logic [65:0] p_step;

    // One Booth step. The accumulator is 33 bits so that subtracting a
    // multiplicand of -2^31 cannot wrap before the shift.
    always_comb begin
        acc_next = p_q[65:33];
        case (p_q[1:0])
            2'b01:   acc_next = p_q[65:33] + mcand_q;
            2'b10:   acc_next = p_q[65:33] - mcand_q;
            default: acc_next = p_q[65:33];
        endcase
        p_step = {acc_next[32], acc_next, p_q[32:1]};
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        p_d      = p_q;
        mcand_d  = mcand_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ctrl_MULT) begin
                    mcand_d = {data_operandA[31], data_operandA};
                    p_d     = {33'b0, data_operandB, 1'b0};
                    count_d = 5'd0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                p_d     = p_step;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    res_lo_d = p_step[32:1];
                    res_hi_d = p_step[64:33];
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= 5'd0;
            p_q      <= 66'd0;
            mcand_q  <= 33'd0;
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            p_q      <= p_d;
            mcand_q  <= mcand_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

`ifdef MULT_OVERFLOW_DETECT_EN
    logic exc_q, exc_d;

    // Overflow: upper word is not a pure sign extension of bit 31.
    always_comb begin
        exc_d = exc_q;
        if (state_q == ST_RUN && count_q == 5'd31)
            exc_d = (p_step[64:33] != {32{p_step[32]}});
    end

    always_ff @(posedge clock) begin
        if (reset) exc_q <= 1'b0;
        else       exc_q <= exc_d;
    end

    assign data_exception = exc_q;
`else
    assign data_exception = 1'b0;
`endif

    assign data_result    = res_lo_q;
    assign data_result_hi = res_hi_q;
    assign data_resultRDY = (state_q == ST_DONE);
    assign busy           = (state_q == ST_RUN);

endmodule

// File: tb/tb_booth_multiplier_32_bit.sv
module tb_booth_multiplier_32_bit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_result_hi;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad   = 0;

    booth_multiplier_32_bit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_result_hi (data_result_hi),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed 64-bit multiplication.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    function automatic logic ref_exc(input logic [63:0] p);
`ifdef MULT_OVERFLOW_DETECT_EN
        longint lo_ext;
        lo_ext = $signed(p[31:0]);
        return (p != lo_ext);
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; the start is sampled on the next posedge (E0).
    // Returns at the negedge after E32 (DONE cycle). inject >= 0 pulses a
    // stray start with other operands during RUN.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [63:0] p;
        p = ref_prod(a, b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        chk("rdy_low_after_start", {63'd0, data_resultRDY}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            chk("busy_run", {63'd0, busy}, 64'd1);
            if (i == inject) begin
                ctrl_MULT     = 1'b1;
                data_operandA = 32'd9;
                data_operandB = 32'd9;
            end else begin
                ctrl_MULT = 1'b0;
            end
            @(negedge clock);
        end
        ctrl_MULT = 1'b0;
        chk("rdy_done", {63'd0, data_resultRDY}, 64'd1);
        chk("busy_done", {63'd0, busy}, 64'd0);
        chk("product", {data_result_hi, data_result}, p);
        chk("exception", {63'd0, data_exception}, {63'd0, ref_exc(p)});
    endtask

    logic [63:0] held;
    logic        saw_activity;

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (2) @(negedge clock);
        chk("rst_result", {data_result_hi, data_result}, 64'd0);
        chk("rst_exc", {63'd0, data_exception}, 64'd0);
        chk("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // 3 * 5, then check pulse width and output hold.
        run_mult(32'd3, 32'd5, -1);
        chk("tp1_const", {data_result_hi, data_result}, 64'h0000_0000_0000_000F);
        @(negedge clock);
        chk("rdy_one_cycle", {63'd0, data_resultRDY}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("hold_result", {data_result_hi, data_result}, 64'h0000_0000_0000_000F);

        run_mult(32'hFFFF_FFF9, 32'd6, -1);
        chk("tp2_const", {data_result_hi, data_result}, 64'hFFFF_FFFF_FFFF_FFD6);
        @(negedge clock);
        run_mult(32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("tp3_const", {data_result_hi, data_result}, 64'h0000_0000_8000_0000);
        @(negedge clock);
        run_mult(32'h0001_0000, 32'h0001_0000, -1);
        @(negedge clock);
        run_mult(32'h8000_0000, 32'h8000_0000, -1);
        @(negedge clock);
        run_mult(32'h7FFF_FFFF, 32'h8000_0000, -1);
        @(negedge clock);
        run_mult(32'h0000_0000, 32'h1234_5678, -1);
        @(negedge clock);

        // Stray start during RUN ignored, then back-to-back start in DONE.
        run_mult(32'd2, 32'd3, 10);
        chk("ignore_const", {data_result_hi, data_result}, 64'd6);
        run_mult(32'd4, 32'hFFFF_FFFC, -1);
        chk("b2b_const", {data_result_hi, data_result}, 64'hFFFF_FFFF_FFFF_FFF0);
        @(negedge clock);

        // Reset mid-RUN with a simultaneous start request.
        data_operandA = 32'd100;
        data_operandB = 32'd100;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (10) @(negedge clock);
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        chk("midrst_result", {data_result_hi, data_result}, 64'd0);
        chk("midrst_exc", {63'd0, data_exception}, 64'd0);
        chk("midrst_rdy", {63'd0, data_resultRDY}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        saw_activity = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY || busy) saw_activity = 1'b1;
        end
        chk("midrst_quiet", {63'd0, saw_activity}, 64'd0);
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("after_rst_const", {data_result_hi, data_result}, 64'd1);

        // Reset during DONE clears the freshly captured result.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("donerst_result", {data_result_hi, data_result}, 64'd0);
        chk("donerst_rdy", {63'd0, data_resultRDY}, 64'd0);
        @(negedge clock);

        // Randomized operands: full-range and small-magnitude mixes.
        repeat (24) begin
            run_mult($urandom, $urandom, -1);
            @(negedge clock);
        end
        repeat (12) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom_range(0, 65535) - 32'd32768;
            rb = $urandom_range(0, 65535) - 32'd32768;
            run_mult(ra, rb, -1);
            held = {data_result_hi, data_result};
            @(negedge clock);
            chk("rand_hold", {data_result_hi, data_result}, ref_prod(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
